// File: rtl/vga_scan_out.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_out
// Purpose  : VGA timing generator and two-stage pixel scan-out producing the
//            packed {hsync, vsync, R, G, B} bus. Optional colour-bar generator
//            enabled by defining VGA_SCAN_TESTPATTERN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scan_out #(
    parameter int COLOR_W  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic                                              clk,
    input  logic                                              reset,
    output logic                                              pix_req,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]      pix_x,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]      pix_y,
    input  logic [3*COLOR_W-1:0]                              pix_data,
    input  logic                                              pix_valid,
    input  logic                                              test_mode,
    input  logic                                              underflow_clr,
    output logic                                              frame_start,
    output logic                                              underflow,
    output logic [3*COLOR_W+1:0]                              vgaData
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PW      = 3 * COLOR_W;

    localparam logic [31:0] c_H_ACT  = 32'(H_ACTIVE);
    localparam logic [31:0] c_H_SS   = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] c_H_SE   = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] c_H_LAST = 32'(H_TOTAL - 1);
    localparam logic [31:0] c_V_ACT  = 32'(V_ACTIVE);
    localparam logic [31:0] c_V_SS   = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] c_V_SE   = 32'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [31:0] c_V_LAST = 32'(V_TOTAL - 1);
    localparam logic        c_SYNC_ON = (SYNC_POL != 0);

    logic [HW-1:0]   h_cnt_q, h_cnt_d;
    logic [VW-1:0]   v_cnt_q, v_cnt_d;
    logic [31:0]     w_h32, w_v32;
    logic            w_h_wrap;
    logic            w_active, w_hsync, w_vsync, w_tm;
    logic            s1_active_q, s1_hsync_q, s1_vsync_q;
    logic [PW-1:0]   w_color;
    logic            w_uf_set;
    logic            underflow_q, underflow_d;
    logic [PW+1:0]   vga_q, vga_d;

`ifdef VGA_SCAN_TESTPATTERN_EN
    logic [2:0]      w_bar;
    logic [2:0]      s1_bar_q;
    logic            s1_tp_q;

    assign w_tm = test_mode;

    // bar = floor(x*8/H_ACTIVE), formed by counting crossed bar boundaries
    always_comb begin
        w_bar = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if ((w_h32 * 32'd8) >= 32'(i * H_ACTIVE)) w_bar = w_bar + 3'd1;
        end
    end
`else
    logic            w_unused_tm;
    assign w_unused_tm = test_mode;
    assign w_tm        = 1'b0;
`endif

    assign w_h32 = 32'(h_cnt_q);
    assign w_v32 = 32'(v_cnt_q);

    always_comb begin
        w_h_wrap = (w_h32 == c_H_LAST);
        h_cnt_d  = w_h_wrap ? '0 : h_cnt_q + HW'(1);
        v_cnt_d  = v_cnt_q;
        if (w_h_wrap) v_cnt_d = (w_v32 == c_V_LAST) ? '0 : v_cnt_q + VW'(1);
    end

    assign w_active = (w_h32 < c_H_ACT) && (w_v32 < c_V_ACT);
    assign w_hsync  = ((w_h32 >= c_H_SS) && (w_h32 < c_H_SE)) ? c_SYNC_ON : ~c_SYNC_ON;
    assign w_vsync  = ((w_v32 >= c_V_SS) && (w_v32 < c_V_SE)) ? c_SYNC_ON : ~c_SYNC_ON;

    assign pix_req     = w_active && !w_tm && !reset;
    assign frame_start = (h_cnt_q == '0) && (v_cnt_q == '0) && !reset;
    assign pix_x       = h_cnt_q;
    assign pix_y       = v_cnt_q;

    // Stage 1 holds the attributes of the pixel whose data returns this cycle
    always_comb begin
        w_color = '0;
`ifdef VGA_SCAN_TESTPATTERN_EN
        if (s1_tp_q) begin
            if (s1_active_q)
                w_color = {{COLOR_W{s1_bar_q[2]}}, {COLOR_W{s1_bar_q[1]}}, {COLOR_W{s1_bar_q[0]}}};
        end else
`endif
        if (s1_active_q && pix_valid) w_color = pix_data;
    end

`ifdef VGA_SCAN_TESTPATTERN_EN
    assign w_uf_set = s1_active_q && !pix_valid && !s1_tp_q;
`else
    assign w_uf_set = s1_active_q && !pix_valid;
`endif

    // A new underflow in the same cycle as a clear must not be lost
    always_comb begin
        underflow_d = underflow_q;
        if (w_uf_set)           underflow_d = 1'b1;
        else if (underflow_clr) underflow_d = 1'b0;
        vga_d = {s1_hsync_q, s1_vsync_q, w_color};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            s1_active_q <= 1'b0;
            s1_hsync_q  <= ~c_SYNC_ON;
            s1_vsync_q  <= ~c_SYNC_ON;
            underflow_q <= 1'b0;
            vga_q       <= {~c_SYNC_ON, ~c_SYNC_ON, {PW{1'b0}}};
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            s1_active_q <= w_active;
            s1_hsync_q  <= w_hsync;
            s1_vsync_q  <= w_vsync;
            underflow_q <= underflow_d;
            vga_q       <= vga_d;
        end
    end

`ifdef VGA_SCAN_TESTPATTERN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_tp_q  <= 1'b0;
            s1_bar_q <= 3'd0;
        end else begin
            s1_tp_q  <= w_tm;
            s1_bar_q <= w_bar;
        end
    end
`endif

    assign underflow = underflow_q;
    assign vgaData   = vga_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scan_out
// Purpose  : Randomised checking of vga_scan_out (default and small mode)
//            against a cycle-index arithmetic model of the video timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_scan_out;

    typedef struct {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp, pol, cw;
    } geom_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, test_mode;

    logic        a_req, a_valid, a_clr, a_fs, a_uf;
    logic [9:0]  a_x, a_y;
    logic [11:0] a_data;
    logic [13:0] a_bus;

    logic        b_req, b_valid, b_clr, b_fs, b_uf;
    logic [4:0]  b_x;
    logic [2:0]  b_y;
    logic [23:0] b_data;
    logic [25:0] b_bus;

    vga_scan_out u_dut_a (
        .clk(clk), .reset(reset), .pix_req(a_req), .pix_x(a_x), .pix_y(a_y),
        .pix_data(a_data), .pix_valid(a_valid), .test_mode(test_mode),
        .underflow_clr(a_clr), .frame_start(a_fs), .underflow(a_uf), .vgaData(a_bus)
    );

    vga_scan_out #(
        .COLOR_W(8), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1)
    ) u_dut_b (
        .clk(clk), .reset(reset), .pix_req(b_req), .pix_x(b_x), .pix_y(b_y),
        .pix_data(b_data), .pix_valid(b_valid), .test_mode(test_mode),
        .underflow_clr(b_clr), .frame_start(b_fs), .underflow(b_uf), .vgaData(b_bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    geom_t ga, gb;

    task automatic chk(input string name, input int cyc, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int ht(geom_t g); return g.ha + g.hfp + g.hs + g.hbp; endfunction
    function automatic int vt(geom_t g); return g.va + g.vfp + g.vs + g.vbp; endfunction
    function automatic int hp(geom_t g, int c); return c % ht(g); endfunction
    function automatic int vp(geom_t g, int c); return (c / ht(g)) % vt(g); endfunction
    function automatic bit act(geom_t g, int c);
        return (hp(g, c) < g.ha) && (vp(g, c) < g.va);
    endfunction

    // Expected bus in cycle c: reflects the coordinate of cycle c-2 and the data returned in c-1
    function automatic logic [63:0] exp_bus(geom_t g, int c, bit v1, logic [63:0] d1, bit tm);
        logic [63:0] col, ones;
        int k, h, v, bar;
        bit hs, vs, pol;
        pol = (g.pol != 0);
        if (c < 2) return ({63'b0, !pol} << (3*g.cw+1)) | ({63'b0, !pol} << (3*g.cw));
        k = c - 2;
        h = hp(g, k);
        v = vp(g, k);
        hs = (h >= g.ha + g.hfp && h < g.ha + g.hfp + g.hs) ? pol : !pol;
        vs = (v >= g.va + g.vfp && v < g.va + g.vfp + g.vs) ? pol : !pol;
        ones = (64'd1 << g.cw) - 64'd1;
        col = 64'd0;
        if (act(g, k)) begin
            if (tm) begin
                bar = h * 8 / g.ha;
                if ((bar & 4) != 0) col = col | (ones << (2*g.cw));
                if ((bar & 2) != 0) col = col | (ones << g.cw);
                if ((bar & 1) != 0) col = col | ones;
            end else if (v1) begin
                col = d1 & ((64'd1 << (3*g.cw)) - 64'd1);
            end
        end
        return ({63'b0, hs} << (3*g.cw+1)) | ({63'b0, vs} << (3*g.cw)) | col;
    endfunction

    task automatic run_phase(input int ncyc, input bit tm);
        bit          a_vprev, b_vprev, a_u, b_u;
        logic [63:0] a_dprev, b_dprev;
        a_vprev = 0; b_vprev = 0; a_u = 0; b_u = 0;
        a_dprev = '0; b_dprev = '0;
        test_mode = tm;
        reset = 1'b1;
        a_valid = 0; a_clr = 0; a_data = '0;
        b_valid = 0; b_clr = 0; b_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("A_rst_bus", -1, a_bus, 64'h3000);
        chk("B_rst_bus", -1, b_bus, 64'h0);
        chk("A_rst_req", -1, a_req, 0);
        chk("A_rst_fs",  -1, a_fs, 0);
        chk("A_rst_uf",  -1, a_uf, 0);
        chk("B_rst_req", -1, b_req, 0);
        reset = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            a_valid = ($urandom_range(0, 15) != 0);
            a_clr   = ($urandom_range(0, 19) == 0);
            a_data  = (c >= 1) ? 12'(hp(ga, c - 1)) : 12'h0;
            if (c == 20)  begin a_valid = 1'b0; a_clr = 1'b1; end
            if (c == 101) a_valid = 1'b1;
            b_valid = ($urandom_range(0, 15) != 0);
            b_clr   = ($urandom_range(0, 19) == 0);
            b_data  = 24'($urandom);
            @(negedge clk);
            chk("A_req", c, a_req, act(ga, c) && !tm);
            chk("A_x",   c, a_x, hp(ga, c));
            chk("A_y",   c, a_y, vp(ga, c));
            chk("A_fs",  c, a_fs, (hp(ga, c) == 0) && (vp(ga, c) == 0));
            chk("A_bus", c, a_bus, exp_bus(ga, c, a_vprev, a_dprev, tm));
            chk("A_uf",  c, a_uf, a_u);
            chk("B_req", c, b_req, act(gb, c) && !tm);
            chk("B_x",   c, b_x, hp(gb, c));
            chk("B_y",   c, b_y, vp(gb, c));
            chk("B_fs",  c, b_fs, (hp(gb, c) == 0) && (vp(gb, c) == 0));
            chk("B_bus", c, b_bus, exp_bus(gb, c, b_vprev, b_dprev, tm));
            chk("B_uf",  c, b_uf, b_u);
            // Hand-computed pins on the model
            if (!tm) begin
                if (c == 657) chk("A_hsync_pre",   c, a_bus[13], 1);
                if (c == 658) chk("A_hsync_start", c, a_bus[13], 0);
                if (c == 753) chk("A_hsync_last",  c, a_bus[13], 0);
                if (c == 754) chk("A_hsync_end",   c, a_bus[13], 1);
                if (c == 102) chk("A_data_x100",   c, a_bus[11:0], 12'd100);
                if (c == 700) chk("A_blank_col",   c, a_bus[11:0], 12'd0);
                if (c == 21)  chk("A_drop_col",    c, a_bus[11:0], 12'd0);
                if (c == 21)  chk("A_uf_setclr",   c, a_uf, 1);
                if (c == 19)  chk("B_hsync_pre",   c, b_bus[25], 0);
                if (c == 20)  chk("B_hsync_start", c, b_bus[25], 1);
                if (c == 116) chk("B_vsync_pre",   c, b_bus[24], 0);
                if (c == 117) chk("B_vsync_start", c, b_bus[24], 1);
                if (c == 161) chk("B_frame_start", c, b_fs, 1);
                if (c == 160) chk("B_frame_pre",   c, b_fs, 0);
            end else begin
                if (c == 2)   chk("A_tp_x0",   c, a_bus[11:0], 12'h000);
                if (c == 81)  chk("A_tp_x79",  c, a_bus[11:0], 12'h000);
                if (c == 82)  chk("A_tp_x80",  c, a_bus[11:0], 12'h00F);
                if (c == 562) chk("A_tp_x560", c, a_bus[11:0], 12'hFFF);
                if (c == 641) chk("A_tp_x639", c, a_bus[11:0], 12'hFFF);
            end
            if (c >= 1 && act(ga, c - 1) && !a_valid && !tm) a_u = 1'b1;
            else if (a_clr) a_u = 1'b0;
            if (c >= 1 && act(gb, c - 1) && !b_valid && !tm) b_u = 1'b1;
            else if (b_clr) b_u = 1'b0;
            a_vprev = a_valid; a_dprev = 64'(a_data);
            b_vprev = b_valid; b_dprev = 64'(b_data);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        ga = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 4};
        gb = '{16, 2, 3, 2, 4, 1, 1, 1, 1, 8};
        reset = 1'b1;
        test_mode = 1'b0;
        run_phase(2500, 1'b0);
`ifdef VGA_SCAN_TESTPATTERN_EN
        run_phase(900, 1'b1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_scan_out.md
# vga_scan_out

Parametrised VGA scan-out engine: generates horizontal/vertical timing, requests one pixel per clock from a framebuffer/pixel source through a fixed-latency fetch port, and emits the packed `vgaData` bus `{hsync, vsync, R, G, B}` consumed by the board pins. It succeeds the fixed 14-bit VGA output path in the core top level. It generalises colour depth, mode timing and sync polarity, and adds underflow detection, a frame strobe and an optional test pattern. The block runs in the pixel clock domain.

## Interface
Parameters:
- `COLOR_W`, 4, bits per colour channel; `vgaData` width is `3*COLOR_W+2`.
- `H_ACTIVE`, 640, visible pixels per line.
- `H_FP`, 16, horizontal front porch (clocks).
- `H_SYNC`, 96, hsync pulse width.
- `H_BP`, 48, horizontal back porch.
- `V_ACTIVE`, 480, visible lines.
- `V_FP`, 10, vertical front porch (lines).
- `V_SYNC`, 2, vsync pulse width (lines).
- `V_BP`, 33, vertical back porch.
- `SYNC_POL`, 0, sync active level (0 = active-low).

Ports:
- `clk`  in  1  pixel clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pix_req`  out  1  pixel request for coordinate `pix_x`/`pix_y`.
- `pix_x`  out  clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)  horizontal counter.
- `pix_y`  out  clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)  vertical counter.
- `pix_data`  in  3*COLOR_W  `{R,G,B}` returned one cycle after `pix_req`.
- `pix_valid`  in  1  qualifies `pix_data`, one cycle after `pix_req`.
- `test_mode`  in  1  selects the internal colour bars (only with the macro).
- `underflow_clr`  in  1  clears `underflow`.
- `frame_start`  out  1  one-cycle pulse at counter position (0,0).
- `underflow`  out  1  sticky: requested pixel not delivered.
- `vgaData`  out  3*COLOR_W+2  `{hsync, vsync, R, G, B}`, registered.

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- `h_cnt` increments every clock and wraps H_TOTAL-1 → 0. On that wrap, `v_cnt` increments and wraps V_TOTAL-1 → 0.
- `pix_x`=`h_cnt`, `pix_y`=`v_cnt`.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE). `pix_req` = active.
- hsync is asserted (level SYNC_POL) when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC. vsync uses the same rule on `v_cnt` with the vertical parameters. Sync is evaluated per clock from counters, not per line.
- Pipeline stage 1: active, hsync and vsync are registered alongside the `pix_data` return.
- Output stage: `vgaData` register loads the sync levels from stage 1. Its colour field loads `pix_data` if stage-1 active && `pix_valid`, else all zero.
- Underflow: stage-1 active && !`pix_valid` sets `underflow`, and zero colour is output for that pixel. `pix_valid` outside active is ignored.
- `underflow_clr` clears the flag. If set and clear occur in the same cycle, set wins.
- `frame_start` = (h_cnt==0 && v_cnt==0), combinational from the counter registers.
- Reset values:
  - counters 0.
  - `pix_req` 0 and `frame_start` 0 while `reset` is high.
  - `underflow` 0.
  - `vgaData` = sync inactive, colour 0: 14'h3000 for defaults.
  - pipeline valid bits 0.
- Reset mid-frame aborts the frame. In the first cycle after release, counters are (0,0), `frame_start`=1 and `pix_req`=1.

## Timing
- Latency from `pix_req`/coordinate at cycle t to the corresponding `vgaData` at cycle t+2 is 2 clocks, for both colour and sync.
- The source must present `pix_data`/`pix_valid` in cycle t+1. There is no backpressure and no stall; the counters never pause.
- One pixel per clock, sustained.
- Frame period is H_TOTAL*V_TOTAL clocks (420000 by default).

## Configuration
- `VGA_SCAN_TESTPATTERN_EN` defined:
  - When `test_mode`=1, colour comes from an internal generator of 8 vertical bars, each H_ACTIVE/8 wide. bar = floor(x*8/H_ACTIVE).
  - R is all-ones if bar[2], G if bar[1], B if bar[0].
  - `pix_req` is held 0 and `underflow` is not set while `test_mode`=1. Sync and latency are unchanged.
- Not defined: `test_mode` is ignored, and there is no generator logic.

## Test plan
- Reset: assert `reset` 3 cycles → `vgaData`=14'h3000, `pix_req`=0. On release, `frame_start`=1 at (0,0), then `pix_req`=1.
- Timing: defaults, run 2 frames → hsync low exactly 96 clocks starting at h_cnt=656, period 800. vsync low for 2 lines starting at line 490. `frame_start` every 420000 clocks.
- Data path: return `pix_data`=x[11:0] with `pix_valid`=1 → `vgaData[11:0]` equals the requested x two clocks later. Colour is 0 during blanking.
- Underflow: drop `pix_valid` for one active pixel → that pixel's colour is 0 and `underflow`=1 stays set. `underflow_clr` clears it. Set and clear in the same cycle → remains 1.
- Parameters: COLOR_W=8, 16×4 active, porches 2/3/2 and 1/1/1, SYNC_POL=1 → 26-bit bus, H_TOTAL=23, V_TOTAL=7, sync active high.
- With `VGA_SCAN_TESTPATTERN_EN`: `test_mode`=1, defaults → x=0..79 black, x=80 blue, x=560..639 white, `pix_req`=0 throughout.
